relu_stream_scheduler: RTL and testbench
========================================

Name: relu_stream_scheduler

Overview:
- Shares one RELU activation unit among NUM_REQ producer channels, such as convolution PE column outputs.
- Each producer offers data with a valid/ready handshake. Grants are round-robin, one beat per grant.
- The block registers the selected beat into the RELU input and carries the requester ID alongside the RELU pipeline.
- It counts beats per frame and pulses done once the last activated result has left the pipeline.

Parameters:
- NUM_REQ, 4: number of requesting channels (≥2).
- DATA_W, 20: activation data width, signed two's complement.
- FRAME_LEN, 784: beats per frame, summed over all channels (≥1).
- ID_W, $clog2(NUM_REQ): width of the requester ID.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- req_valid  in  NUM_REQ  per-channel data valid.
- req_data  in  NUM_REQ*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; transfer happens when req_valid[i] && req_ready[i].
- relu_in  out  DATA_W  registered operand to the shared RELU unit.
- relu_out  in  DATA_W  RELU result, exactly 1 cycle after relu_in.
- out_valid  out  1  activated result valid.
- out_data  out  DATA_W  activated result; equals relu_out.
- out_id  out  ID_W  channel that produced out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs are 0 on the first edge with rst=1, including req_ready, relu_in, out_valid, out_id, busy and done.
  - FSM goes to IDLE; rr_ptr=0; beat_cnt=0; tag pipeline cleared.
  - Reset mid-frame discards in-flight beats; out_valid is 0 on the cycle after reset is applied.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: req_ready=0. start=1 → RUN; beat_cnt←0; rr_ptr keeps its value.
  - RUN:
    - Grant goes to the first channel i with req_valid[i]=1, searching circularly from rr_ptr. req_ready is combinational from req_valid and rr_ptr; at most one bit is high.
    - On transfer: relu_in←req_data[g]; tag stage 1 ← {1,g}; rr_ptr←(g+1) mod NUM_REQ; beat_cnt←beat_cnt+1.
    - With no valid request: relu_in←0, tag valid←0, rr_ptr unchanged.
    - A transfer with beat_cnt==FRAME_LEN-1 → DRAIN. req_ready is 0 from the next cycle.
  - DRAIN: req_ready=0; wait until the tag pipeline is empty (2 cycles) → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored. No queuing.
- Latency from transfer edge: relu_in on edge +1; out_valid/out_data/out_id on edge +2.
  - out_valid = tag stage 2 valid; out_id = tag stage 2 id; out_data = relu_out.
- There is no output backpressure. The downstream consumer must accept every out_valid beat.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A requester that holds req_valid continuously gets a grant at least once every NUM_REQ transfers.
- beat_cnt is $clog2(FRAME_LEN+1) bits wide and never wraps within a frame.
- relu_out is never X-checked here. The RELU unit guarantees a defined value.

Decomposition:
- Package act_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
  - localparam RELU_LAT=1;
  - localparam PIPE_LAT=2.
- One sub-module, rr_arbiter: inputs req[NUM_REQ] and ptr; outputs a one-hot gnt plus gnt_idx.
  - Purely combinational, reused by other shared-resource controllers.
  - The FSM, counters and tag pipeline stay in relu_stream_scheduler.
- The bench instantiates RELU alongside this block, with relu_in → RELU → relu_out.

Test Plan:
- Reset then idle: assert rst for 2 cycles with req_valid=4'hF → req_ready=0, out_valid=0, busy=0 throughout while no start is given.
- Round-robin: FRAME_LEN=8, all channels valid, data ch0..3 = 5, -3, 7, 0 → out_id sequence 0,1,2,3,0,1,2,3; out_data 5,0,7,0 repeated. First out_valid arrives 2 cycles after the first transfer. done pulses once, 3 cycles after the 8th transfer.
- Sparse requests: only ch2 valid (data 100), rr_ptr=3 → grant ch2; rr_ptr becomes 3. Then raise ch0 and ch3 together → ch3 is granted before ch0.
- Negative saturation boundary: data 20'h80000 and 20'h7FFFF → out_data 0 and 20'h7FFFF respectively.
- Reset mid-frame: rst asserted for 1 cycle after 3 of 8 transfers, with 2 beats in flight → out_valid=0 on the following cycles, state IDLE, no done pulse. A new start then completes 8 fresh beats.
- start ignored: pulse start during RUN and during DRAIN → beat count is unaffected and exactly one done pulse occurs per accepted start.

Source files
------------

// File: rtl/relu_stream_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package : act_sched_pkg
// Brief   : Shared types and latency constants for the RELU stream scheduler.
// Rev     : 1.0
// ============================================================================
package act_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int RELU_LAT = 1;
    // One register stage ahead of the RELU unit plus the unit itself.
    localparam int PIPE_LAT = RELU_LAT + 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; first requester at or after ptr.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] w_cand [NUM_REQ];
    logic            w_found;

    // Candidate k is the k-th channel in circular order starting at ptr.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
            assign w_cand[k] = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found          = 1'b1;
                gnt[w_cand[k]]   = 1'b1;
                gnt_idx          = w_cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module : relu_stream_scheduler
// Brief  : Round-robin sharing of one RELU unit among producer channels, with
//          per-frame beat counting and an end-of-frame done pulse.
// Rev    : 1.0
// ============================================================================
module relu_stream_scheduler
    import act_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 20,
    parameter int FRAME_LEN = 784,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           relu_in,
    input  logic [DATA_W-1:0]           relu_out,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [ID_W-1:0]             out_id,
    output logic                        busy,
    output logic                        done
);

    localparam int                 c_CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]    c_LAST_ID   = ID_W'(NUM_REQ - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic [DATA_W-1:0]     r_relu_in;
    logic [PIPE_LAT-1:0]   r_tag_vld;
    logic [ID_W-1:0]       r_tag_id [PIPE_LAT];
    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_W-1:0]       w_gnt_idx;
    logic [DATA_W-1:0]     w_chan_data [NUM_REQ];
    logic                  w_run;
    logic                  w_xfer;
    logic                  w_last;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_chan_data[i] = req_data[i*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_run  = (r_state == RUN);
    assign w_xfer = w_run && (|req_valid);
    assign w_last = (r_beat_cnt == c_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                req_ready = w_gnt;
                if (w_xfer && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            // Leave once the last beat has passed the RELU input register.
            DRAIN: begin
                if (!(|r_tag_vld[PIPE_LAT-2:0])) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_relu_in  <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_beat_cnt <= '0;
            end
            if (w_xfer) begin
                r_relu_in  <= w_chan_data[w_gnt_idx];
                r_rr_ptr   <= (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + ID_W'(1);
                r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end else begin
                r_relu_in  <= '0;
            end
        end
    end

    // Requester tags travel alongside the data so out_id lines up with relu_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[PIPE_LAT-2:0], w_xfer};
            r_tag_id[0] <= w_xfer ? w_gnt_idx : '0;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign relu_in   = r_relu_in;
    assign out_valid = r_tag_vld[PIPE_LAT-1];
    assign out_id    = r_tag_id[PIPE_LAT-1];
    assign out_data  = relu_out;

endmodule
`default_nettype wire

// File: tb/tb_relu_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_relu_stream_scheduler
// Brief  : Directed, table-driven bench for relu_stream_scheduler with a RELU model.
// Rev    : 1.0
// ============================================================================
module tb_relu_stream_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 20;
    localparam int FRAME_LEN = 8;
    localparam int ID_W      = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         relu_in;
    logic [DATA_W-1:0]         relu_out;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      busy;
    logic                      done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [ID_W+DATA_W-1:0] sb_q [$];

    typedef struct {
        logic [3:0]        valid;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] d3;
        logic [ID_W-1:0]   gnt;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    vec_t vec [17];

    relu_stream_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ID_W      (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .relu_in   (relu_in),
        .relu_out  (relu_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Shared RELU unit: one-cycle registered max(x, 0).
    always_ff @(posedge clk) begin
        if (rst) relu_out <= '0;
        else     relu_out <= relu_in[DATA_W-1] ? '0 : relu_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_beat", {10'd0, out_id, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("out_beat_id_data", {10'd0, out_id, out_data}, {10'd0, sb_q.pop_front()});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d,
                                input logic [ID_W-1:0] g, input logic [DATA_W-1:0] o);
        vec_t r;
        r.valid = v; r.d0 = a; r.d1 = b; r.d2 = c; r.d3 = d; r.gnt = g; r.exp_out = o;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        req_valid = v.valid;
        req_data  = {v.d3, v.d2, v.d1, v.d0};
    endtask

    function automatic logic [3:0] exp_ready(input vec_t v);
        logic [3:0] one;
        one = 4'b0001;
        return (v.valid != 4'b0) ? (one << v.gnt) : 4'b0000;
    endfunction

    // Runs vectors lo..hi as one frame; poke pulses start during RUN and DRAIN.
    task automatic run_frame(input int lo, input int hi, input bit poke);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = lo; i <= hi; i++) begin
            apply(vec[i]);
            start = poke && (i == lo + 2);
            #1;
            check("req_ready_grant", {28'd0, req_ready}, {28'd0, exp_ready(vec[i])});
            check("out_valid_latency", {31'd0, out_valid},
                  (i - lo >= 2) ? {31'd0, (vec[i-2].valid != 4'b0)} : 32'd0);
            check("busy_in_run", {31'd0, busy}, 32'd1);
            if (vec[i].valid != 4'b0) sb_q.push_back({vec[i].gnt, vec[i].exp_out});
            tick();
        end
        start     = poke;
        req_valid = 4'hF;
        #1;
        check("drain_ready_low", {28'd0, req_ready}, 32'd0);
        check("drain_out_valid", {31'd0, out_valid}, {31'd0, (vec[hi-1].valid != 4'b0)});
        check("drain_no_done_1", {31'd0, done}, 32'd0);
        tick();
        start = 1'b0;
        check("drain_last_out", {31'd0, out_valid}, 32'd1);
        check("drain_no_done_2", {31'd0, done}, 32'd0);
        tick();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("after_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {28'd0, req_ready}, 32'd0);
        tick();
        tick();
        check("done_count_per_frame", done_cnt, d0 + 1);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        req_valid = 4'h0;
    endtask

    initial begin
        // Frame A: all channels valid, strict rotation.
        vec[0]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd0, 20'd5);
        vec[1]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd1, 20'd0);
        vec[2]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd2, 20'd7);
        vec[3]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd3, 20'd0);
        vec[4]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd0, 20'd5);
        vec[5]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd1, 20'd0);
        vec[6]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd2, 20'd7);
        vec[7]  = mk(4'hF, 20'd5, 20'hFFFFD, 20'd7, 20'd0, 2'd3, 20'd0);
        // Frame B: sparse requests, idle cycle, saturation boundaries.
        vec[8]  = mk(4'b0100, 20'd0,  20'd0,      20'd100,  20'd0,  2'd2, 20'd100);
        vec[9]  = mk(4'b0100, 20'd0,  20'd0,      20'd100,  20'd0,  2'd2, 20'd100);
        vec[10] = mk(4'b1001, 20'd11, 20'd0,      20'd0,    20'd33, 2'd3, 20'd33);
        vec[11] = mk(4'b0001, 20'd11, 20'd0,      20'd0,    20'd0,  2'd0, 20'd11);
        vec[12] = mk(4'b0000, 20'd0,  20'd0,      20'd0,    20'd0,  2'd0, 20'd0);
        vec[13] = mk(4'b0010, 20'd0,  20'h80000,  20'd0,    20'd0,  2'd1, 20'd0);
        vec[14] = mk(4'b0010, 20'd0,  20'h7FFFF,  20'd0,    20'd0,  2'd1, 20'h7FFFF);
        vec[15] = mk(4'b1111, 20'd1,  20'd2,      20'hFFFFF, 20'd4, 2'd2, 20'd0);
        vec[16] = mk(4'b1010, 20'd1,  20'd2,      20'd0,    20'd4,  2'd3, 20'd4);

        rst       = 1'b1;
        start     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_req_ready", {28'd0, req_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_relu_in", {12'd0, relu_in}, 32'd0);
            check("rst_out_id", {30'd0, out_id}, 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_no_start_ready", {28'd0, req_ready}, 32'd0);
            check("idle_no_start_busy", {31'd0, busy}, 32'd0);
            check("idle_no_start_valid", {31'd0, out_valid}, 32'd0);
        end
        req_valid = 4'h0;

        run_frame(0, 7, 1'b0);
        run_frame(8, 16, 1'b1);

        // Reset after three transfers, with two beats still in flight.
        start = 1'b1;
        tick();
        start    = 1'b0;
        req_data = {20'd9, 20'd9, 20'd9, 20'd9};
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'hF;
            #1;
            check("midrst_grant", {28'd0, req_ready}, 32'd1 << k);
            if (k < 2) sb_q.push_back({2'(k), 20'd9});
            tick();
        end
        req_valid = 4'h0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'hF;
        #1;
        check("midrst_out_valid_0", {31'd0, out_valid}, 32'd0);
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);
        check("midrst_idle_ready", {28'd0, req_ready}, 32'd0);
        check("midrst_no_done", {31'd0, done}, 32'd0);
        tick();
        check("midrst_out_valid_1", {31'd0, out_valid}, 32'd0);
        check("midrst_no_done_2", {31'd0, done}, 32'd0);
        tick();
        check("midrst_out_valid_2", {31'd0, out_valid}, 32'd0);
        check("midrst_done_count", done_cnt, 32'd2);
        check("midrst_scoreboard", sb_q.size(), 32'd0);
        req_valid = 4'h0;

        run_frame(0, 7, 1'b0);
        check("total_done_count", done_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
